// File: rtl/mmio_io_responder_if.sv
// mmio_io_responder_if: CPU data-bus signals between a load/store master and an MMIO target
//   addr     16-bit CPU data address
//   rd_en    load strobe, one cycle per access
//   wr_en    store strobe, one cycle per access
//   wr_data  16-bit store data
//   rd_data  16-bit load data, 0 unless rd_valid
//   rd_valid one-cycle pulse the cycle after a hitting load
interface mmio_io_responder_if;
    logic [15:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid;
    modport master (output addr, rd_en, wr_en, wr_data, input rd_data, rd_valid);
    modport slave  (input addr, rd_en, wr_en, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: 4-word MMIO window serving debounced switches, LEDs, hex display and sticky status
//   clk/reset  system clock, synchronous active-high reset
//   bus        slave side of the CPU data bus (mmio_io_responder_if)
//   switches   raw asynchronous board switches
//   leds       LED register
//   seg_an     digit anodes, active-low, one lit at a time
//   seg_cat    segments {g,f,e,d,c,b,a}, active-low
module mmio_io_responder #(
    parameter logic [15:0] BASE_ADDR       = 16'hFFF0,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          SCAN_DIV        = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    mmio_io_responder_if.slave         bus,
    input  logic [15:0]                switches,
    output logic [15:0]                leds,
    output logic [3:0]                 seg_an,
    output logic [6:0]                 seg_cat
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [15:0]   r_sync1, r_sw_s, r_cand, r_sw_db, r_leds, r_hex, r_rd_data;
    logic [DW-1:0] r_db_cnt;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_digit;
    logic          r_sticky, r_rd_valid;
    logic [3:0]    r_an;
    logic [6:0]    r_cat;

    logic          w_hit, w_rd_hit, w_wr_hit, w_db_fire;
    logic [1:0]    w_off;
    logic [15:0]   w_rd_val;
    logic [3:0]    w_nib;
    logic [6:0]    w_cat;

    assign w_hit    = bus.addr[15:2] == BASE_ADDR[15:2];
    assign w_off    = bus.addr[1:0];
    assign w_rd_hit = bus.rd_en & w_hit;
    assign w_wr_hit = bus.wr_en & w_hit;
    assign w_rd_val = w_off == 2'd0 ? r_sw_db :
                      w_off == 2'd1 ? r_leds  :
                      w_off == 2'd2 ? r_hex   : {15'b0, r_sticky};
    // counter saturates at its terminal value, so a settled candidate that differs
    // from sw_db is committed on the first edge it has been stable long enough
    assign w_db_fire = (r_db_cnt == DEB_LAST) && (r_cand != r_sw_db);
    assign w_nib     = r_hex[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_cat = 7'b1111111;
        case (w_nib)
            4'h0: w_cat = 7'b1000000;
            4'h1: w_cat = 7'b1111001;
            4'h2: w_cat = 7'b0100100;
            4'h3: w_cat = 7'b0110000;
            4'h4: w_cat = 7'b0011001;
            4'h5: w_cat = 7'b0010010;
            4'h6: w_cat = 7'b0000010;
            4'h7: w_cat = 7'b1111000;
            4'h8: w_cat = 7'b0000000;
            4'h9: w_cat = 7'b0010000;
            4'hA: w_cat = 7'b0001000;
            4'hB: w_cat = 7'b0000011;
            4'hC: w_cat = 7'b1000110;
            4'hD: w_cat = 7'b0100001;
            4'hE: w_cat = 7'b0000110;
            4'hF: w_cat = 7'b0001110;
            default: w_cat = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sw_s     <= '0;
            r_cand     <= '0;
            r_db_cnt   <= '0;
            r_sw_db    <= '0;
            r_sticky   <= 1'b0;
            r_leds     <= '0;
            r_hex      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_scan     <= '0;
            r_digit    <= '0;
            r_an       <= 4'b1110;
            r_cat      <= 7'b1000000;
        end else begin
            r_sync1 <= switches;
            r_sw_s  <= r_sync1;
            if (r_sw_s != r_cand) begin
                r_cand   <= r_sw_s;
                r_db_cnt <= '0;
            end else if (r_db_cnt != DEB_LAST) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_db_fire)
                r_sw_db <= r_cand;
            // a new switch change outranks a status read-clear on the same edge
            r_sticky   <= w_db_fire | (r_sticky & ~(w_rd_hit && w_off == 2'd3));
            r_rd_valid <= w_rd_hit;
            r_rd_data  <= w_rd_hit ? w_rd_val : 16'h0000;
            if (w_wr_hit && w_off == 2'd1)
                r_leds <= bus.wr_data;
            if (w_wr_hit && w_off == 2'd2)
                r_hex <= bus.wr_data;
            r_scan  <= r_scan == SCAN_LAST ? '0 : r_scan + 1'b1;
            r_digit <= r_scan == SCAN_LAST ? r_digit + 1'b1 : r_digit;
            r_an    <= ~(4'b0001 << r_digit);
            r_cat   <= w_cat;
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign leds         = r_leds;
    assign seg_an       = r_an;
    assign seg_cat      = r_cat;
endmodule

// File: tb/tb_mmio_io_responder.sv
// tb_mmio_io_responder: randomized and directed bench for mmio_io_responder against a behavioural model
module tb_mmio_io_responder;
    localparam int DEB = 8;
    localparam int SD  = 4;
    localparam logic [15:0] BASE = 16'hFFF0;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] switches = 16'h0000;
    logic [15:0] leds;
    logic [3:0]  seg_an;
    logic [6:0]  seg_cat;

    mmio_io_responder_if bus();

    mmio_io_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .bus(bus), .switches(switches),
        .leds(leds), .seg_an(seg_an), .seg_cat(seg_cat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: registers as plain variables, display digit from elapsed cycles,
    // debounce as "the DEB switch samples ending three edges ago all agree".
    logic [15:0] m_leds, m_hex, m_swdb, m_rd;
    logic        m_sticky, m_rv;
    logic        m_ok = 1'b0;
    logic [3:0]  m_an;
    logic [6:0]  m_cat;
    int          m_n;
    logic [15:0] hist [DEB+3];

    always @(posedge clk) begin : model
        logic        hit, fire, rd_status;
        logic [1:0]  off;
        logic [15:0] val;
        int          d;
        if (reset) begin
            m_leds = 0; m_hex = 0; m_swdb = 0; m_sticky = 0; m_rv = 0; m_rd = 0;
            m_an = 4'b1110; m_cat = 7'b1000000; m_n = 0;
            for (int i = 0; i < DEB + 3; i++) hist[i] = 16'h0000;
        end else begin
            hit = bus.addr[15:2] == BASE[15:2];
            off = bus.addr[1:0];
            val = off == 0 ? m_swdb : off == 1 ? m_leds : off == 2 ? m_hex : {15'b0, m_sticky};
            m_rv = bus.rd_en && hit;
            m_rd = m_rv ? val : 16'h0000;
            rd_status = m_rv && off == 3;
            d = (m_n / SD) % 4;
            m_an = ~(4'b0001 << d);
            m_cat = SEG[4'((m_hex >> (4 * d)) & 16'hF)];
            for (int i = DEB + 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = switches;
            fire = hist[3] != m_swdb;
            for (int i = 3; i <= DEB + 2; i++) if (hist[i] != hist[3]) fire = 0;
            if (fire) m_swdb = hist[3];
            m_sticky = fire || (m_sticky && !rd_status);
            if (bus.wr_en && hit && off == 1) m_leds = bus.wr_data;
            if (bus.wr_en && hit && off == 2) m_hex = bus.wr_data;
            m_n++;
        end
        m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("leds", leds, m_leds);
            chk("rd_valid", bus.rd_valid, m_rv);
            chk("rd_data", bus.rd_data, m_rd);
            chk("seg_an", seg_an, m_an);
            chk("seg_cat", seg_cat, m_cat);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        bus.addr = a; bus.rd_en = r; bus.wr_en = w; bus.wr_data = d;
    endtask

    initial begin
        drive(16'h0000, 0, 0, 16'h0000);
        repeat (3) cyc();
        reset = 0;
        chk("rst_leds", leds, 16'h0000);
        chk("rst_an", seg_an, 4'b1110);
        chk("rst_cat", seg_cat, 7'b1000000);
        chk("rst_rv", bus.rd_valid, 1'b0);
        drive(BASE, 1, 0, 0); cyc();
        chk("rd_sw_valid", bus.rd_valid, 1'b1);
        chk("rd_sw_data", bus.rd_data, 16'h0000);

        drive(BASE + 1, 0, 1, 16'hA5C3); cyc();
        chk("led_wr", leds, 16'hA5C3);
        chk("model_led", m_leds, 16'hA5C3);
        drive(BASE + 1, 1, 0, 0); cyc();
        chk("led_rd_valid", bus.rd_valid, 1'b1);
        chk("led_rd_data", bus.rd_data, 16'hA5C3);
        drive(16'h00FF, 1, 0, 0); cyc();
        chk("miss_valid", bus.rd_valid, 1'b0);
        chk("miss_data", bus.rd_data, 16'h0000);

        // sw_db takes the new value on the tenth edge after the first edge that samples it
        switches = 16'h0007;
        drive(BASE, 1, 0, 0);
        for (int j = 1; j <= 12; j++) begin
            cyc();
            if (j == 11) chk("db_before", bus.rd_data, 16'h0000);
            if (j == 12) chk("db_after", bus.rd_data, 16'h0007);
        end
        chk("model_swdb", m_swdb, 16'h0007);
        drive(BASE + 3, 1, 0, 0); cyc();
        chk("status_set", bus.rd_data, 16'h0001);
        cyc();
        chk("status_clr", bus.rd_data, 16'h0000);
        drive(BASE, 0, 0, 0);
        switches = 16'h0000;
        repeat (5) cyc();
        switches = 16'h0007;
        repeat (20) cyc();
        drive(BASE, 1, 0, 0); cyc();
        chk("glitch_sw", bus.rd_data, 16'h0007);
        drive(BASE + 3, 1, 0, 0); cyc();
        chk("glitch_status", bus.rd_data, 16'h0000);

        drive(BASE + 2, 0, 1, 16'h1234); cyc();
        drive(BASE + 2, 1, 1, 16'hBEEF); cyc();
        chk("rw_old", bus.rd_data, 16'h1234);
        drive(BASE + 2, 1, 0, 0); cyc();
        chk("rw_new", bus.rd_data, 16'hBEEF);
        chk("model_hex", m_hex, 16'hBEEF);

        drive(0, 0, 0, 0);
        reset = 1; cyc();
        reset = 0;
        drive(BASE + 2, 0, 1, 16'h0D8F); cyc();
        drive(0, 0, 0, 0);
        for (int k = 2; k <= 18; k++) begin
            cyc();
            if (k == 2)  begin chk("scan0_an", seg_an, 4'b1110); chk("scan0_cat", seg_cat, 7'b0001110); end
            if (k == 6)  begin chk("scan1_an", seg_an, 4'b1101); chk("scan1_cat", seg_cat, 7'b0000000); end
            if (k == 10) begin chk("scan2_an", seg_an, 4'b1011); chk("scan2_cat", seg_cat, 7'b0100001); end
            if (k == 14) begin chk("scan3_an", seg_an, 4'b0111); chk("scan3_cat", seg_cat, 7'b1000000); end
            if (k == 18) begin chk("wrap_an", seg_an, 4'b1110); chk("wrap_cat", seg_cat, 7'b0001110); end
        end

        drive(BASE + 1, 0, 1, 16'h1111); cyc();
        drive(BASE + 1, 1, 0, 0); cyc();
        chk("pre_rst_valid", bus.rd_valid, 1'b1);
        reset = 1; cyc();
        chk("rst_drop_valid", bus.rd_valid, 1'b0);
        chk("rst_leds2", leds, 16'h0000);
        drive(BASE + 2, 1, 1, 16'h5555); cyc();
        chk("rst_no_write", leds, 16'h0000);
        chk("rst_no_valid", bus.rd_valid, 1'b0);
        reset = 0;
        // switches are still 7, so sw_db changes on the 11th edge after this reset,
        // the same edge a STATUS read is being accepted
        drive(BASE + 3, 1, 0, 0);
        for (int j = 1; j <= 13; j++) begin
            cyc();
            if (j == 11) chk("sticky_pre", bus.rd_data, 16'h0000);
            if (j == 12) chk("sticky_setwins", bus.rd_data, 16'h0001);
            if (j == 13) chk("sticky_clr", bus.rd_data, 16'h0000);
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 4) != 0 ? BASE + 16'($urandom_range(0, 3)) : 16'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 15) == 0)
                switches = $urandom_range(0, 1) ? 16'($urandom) : switches ^ 16'(1 << $urandom_range(0, 15));
            reset = $urandom_range(0, 399) == 0;
            cyc();
        end
        reset = 0;
        drive(0, 0, 0, 0);
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
